// File: rtl/vid_pkg.sv
// Shared types and constants for the video timing generator and its pattern source.
package vid_pkg;

    localparam int COORD_W = 12;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        GRAD  = 2'd1,
        GREY  = 2'd2,
        CHECK = 2'd3
    } pattern_e;

    function automatic int span_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vid_pattern.sv
// Combinational test-pattern colour source, addressed by pixel coordinate.
module vid_pattern
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE
) (
    input  logic [COORD_W-1:0] x,
    input  logic [7:0]         y,
    input  pattern_e           sel,
    input  logic [7:0]         gamma,
    output logic [23:0]        rgb
);

    // Narrow screens still get one-pixel bars rather than a divide by zero.
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic [2:0] bar;
    assign bar = 3'(x / COORD_W'(BAR_W));

    always_comb begin
        rgb = '0;
        case (sel)
            BARS:    rgb = BAR_RGB[bar];
            GRAD:    rgb = {x[7:0], y, x[7:0] ^ y};
            GREY:    rgb = {3{gamma}};
            CHECK:   rgb = (x[4] ^ y[4]) ? 24'h000000 : 24'hFFFFFF;
            default: rgb = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, sync generation and run control; every output registered one clock after the counters.
module video_timing_gen
    import vid_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [1:0]         pattern_sel_i,
    input  logic [7:0]         gamma_i,
    output logic [23:0]        rgb_o,
    output logic               dv_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic               line_end_o,
    output logic               frame_start_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o
);

    localparam timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_TOTAL = span_total(H_TIM);
    localparam int V_TOTAL = span_total(V_TIM);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_timing
            $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit coordinate range");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    pattern_e           pat_q;

    logic     h_last, v_last, at_origin, running;
    logic     active_p0, hsync_p0, vsync_p0;
    pattern_e sel_p0;
    logic [23:0] rgb_p0;

    assign h_last    = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last    = (int'(v_cnt) == V_TOTAL - 1);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign running   = (state == RUN);

    assign active_p0 = running && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hsync_p0  = running && (int'(h_cnt) >= H_ACTIVE + H_FP)
                               && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign vsync_p0  = running && (int'(v_cnt) >= V_ACTIVE + V_FP)
                               && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

    // The first pixel of a frame already uses the selection being captured into the shadow.
    assign sel_p0 = at_origin ? pattern_e'(pattern_sel_i) : pat_q;

    vid_pattern #(
        .H_ACTIVE(H_ACTIVE)
    ) u_pattern (
        .x    (h_cnt),
        .y    (v_cnt[7:0]),
        .sel  (sel_p0),
        .gamma(gamma_i),
        .rgb  (rgb_p0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            pat_q <= BARS;
        end else begin
            if (at_origin) begin
                pat_q <= pattern_e'(pattern_sel_i);
            end
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (!en_i) begin
                                state <= IDLE;
                            end
                        end else begin
                            v_cnt <= v_cnt + COORD_W'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + COORD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_o         <= '0;
            dv_o          <= 1'b0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
        end else begin
            rgb_o         <= active_p0 ? rgb_p0 : '0;
            dv_o          <= active_p0;
            hs_o          <= hsync_p0 ? HS_POL : ~HS_POL;
            vs_o          <= vsync_p0 ? VS_POL : ~VS_POL;
            line_end_o    <= dv_o && !active_p0;
            frame_start_o <= active_p0 && at_origin;
            x_o           <= active_p0 ? h_cnt : '0;
            y_o           <= active_p0 ? v_cnt : '0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: per-cycle expected output frames are queued by the stimulus, a monitor compares from frame_start.
module tb_video_timing_gen;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [7:0]  gamma_i = 8'h00;
    logic [23:0] rgb_o;
    logic        dv_o, hs_o, vs_o, line_end_o, frame_start_o;
    logic [11:0] x_o, y_o;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .pattern_sel_i(pattern_sel_i),
        .gamma_i      (gamma_i),
        .rgb_o        (rgb_o),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .line_end_o   (line_end_o),
        .frame_start_o(frame_start_o),
        .x_o          (x_o),
        .y_o          (y_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dv;
        logic        hs;
        logic        vs;
        logic        le;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
    } obs_t;

    localparam logic [23:0] BAR_TAB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam obs_t IDLE_OBS = '{dv: 1'b0, hs: 1'b1, vs: 1'b1, le: 1'b0, fs: 1'b0,
                                  x: 12'd0, y: 12'd0, rgb: 24'h0};

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_arm = 1'b0;

    // Expected output k cycles after frame_start (lines of 14 clocks, 8 active, hsync at 10..11, vsync on line 5).
    function automatic obs_t expect_at(int k, int sel, logic [7:0] g);
        obs_t e;
        int l, p;
        l = k / HT;
        p = k % HT;
        e = '0;
        e.dv = (l < 4) && (p < 8);
        e.hs = !(p == 10 || p == 11);
        e.vs = (l != 5);
        e.le = (l < 4) && (p == 8);
        e.fs = (k == 0);
        if (e.dv) begin
            e.x = 12'(p);
            e.y = 12'(l);
            case (sel)
                0:       e.rgb = BAR_TAB[p];
                1:       e.rgb = {8'(p), 8'(l), 8'(p ^ l)};
                2:       e.rgb = {g, g, g};
                default: e.rgb = 24'hFFFFFF;
            endcase
        end
        return e;
    endfunction

    function automatic obs_t now_obs();
        return '{dv: dv_o, hs: hs_o, vs: vs_o, le: line_end_o, fs: frame_start_o,
                 x: x_o, y: y_o, rgb: rgb_o};
    endfunction

    task automatic compare(input string name, input obs_t a, input obs_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got dv=%b hs=%b vs=%b le=%b fs=%b x=%0d y=%0d rgb=%h, want dv=%b hs=%b vs=%b le=%b fs=%b x=%0d y=%0d rgb=%h",
                     name, a.dv, a.hs, a.vs, a.le, a.fs, a.x, a.y, a.rgb,
                     e.dv, e.hs, e.vs, e.le, e.fs, e.x, e.y, e.rgb);
        end
    endtask

    task automatic push_frame(input int sel, input logic [7:0] g);
        for (int k = 0; k < FT; k++) begin
            exp_q.push_back(expect_at(k, sel, g));
        end
    endtask

    task automatic monitor();
        bit   synced;
        int   k;
        obs_t e;
        synced = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (!mon_arm || rst) begin
                synced = 1'b0;
                k = 0;
            end else begin
                if (!synced && frame_start_o) begin
                    synced = 1'b1;
                    k = 0;
                end
                if (synced && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    compare($sformatf("cycle%0d", k), now_obs(), e);
                    k = (k + 1) % FT;
                    if (exp_q.size() == 0) synced = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected cycles never observed, want 0", exp_q.size());
            exp_q.delete();
        end
        mon_arm = 1'b0;
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start_o && n < budget);
        if (!frame_start_o) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_fs: frame_start_o=0 after %0d cycles, want 1", n);
        end
    endtask

    initial begin
        int lat;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset_state", now_obs(), IDLE_OBS);

        // Two free-running gradient frames from reset release
        @(posedge clk); #1;
        rst = 1'b0;
        en_i = 1'b1;
        pattern_sel_i = 2'd1;
        mon_arm = 1'b1;
        push_frame(1, 8'h00);
        push_frame(1, 8'h00);
        drain(400);

        // Bars, then a mid-frame switch to grey that lands on the next frame
        pattern_sel_i = 2'd0;
        wait_fs(200);
        @(posedge clk); #1;
        mon_arm = 1'b1;
        push_frame(0, 8'h00);
        push_frame(2, 8'h80);
        wait_fs(200);
        repeat (20) @(posedge clk);
        #1;
        pattern_sel_i = 2'd2;
        gamma_i = 8'h80;
        drain(400);

        // en_i dropped on line 1: frame completes, then the generator idles
        @(posedge clk); #1;
        mon_arm = 1'b1;
        push_frame(2, 8'h80);
        wait_fs(200);
        repeat (20) @(posedge clk);
        #1;
        en_i = 1'b0;
        drain(200);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            compare($sformatf("idle_hold%0d", i), now_obs(), IDLE_OBS);
        end

        // Restart: frame_start two clocks after en_i rises
        @(posedge clk); #1;
        en_i = 1'b1;
        mon_arm = 1'b1;
        push_frame(2, 8'h80);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!frame_start_o && lat < 10);
        n_vec++;
        if (lat != 2 || !frame_start_o) begin
            n_err++;
            $display("FAIL restart_latency: got %0d clocks (fs=%b), want 2", lat, frame_start_o);
        end
        drain(200);

        // Asynchronous reset mid-line, away from any clock edge
        wait_fs(200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", now_obs(), IDLE_OBS);
        pattern_sel_i = 2'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_arm = 1'b1;
        push_frame(3, 8'h80);
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
